// File: rtl/fan_pwm_ramp_pkg.sv
// Shared fan definitions: ramp state encoding and PWM prescaler sizing.
// Also used by the upstream fan_controller.
package fan_pwm_ramp_pkg;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RAMP_DN = 2'd2,
        ST_HOLD    = 2'd3
    } fan_state_e;

    // Clocks per duty slot, truncated, never below 1.
    function automatic int calc_div(input int sys_mhz, input int n, input int pwm_hz);
        longint num;
        longint den;
        longint q;
        num = longint'(sys_mhz) * 1000000;
        den = longint'(pwm_hz) << n;
        q   = num / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/fan_pwm_ramp_if.sv
// Duty request / PWM status bundle between the fan FSM and the PWM ramp stage.
interface fan_pwm_ramp_if #(
    parameter int N = 12
);
    logic         en;
    logic [N-1:0] duty_target;
    logic         pwm;
    logic [N-1:0] duty_now;
    logic         period_tick;
    logic         ramping;
    logic         at_target;

    modport master (
        output en, duty_target,
        input  pwm, duty_now, period_tick, ramping, at_target
    );

    modport slave (
        input  en, duty_target,
        output pwm, duty_now, period_tick, ramping, at_target
    );
endinterface

// File: rtl/fan_pwm_ramp_pwm_slot_gen.sv
// Prescaler plus N-bit duty-slot counter; flags the last clock of each PWM period.
module pwm_slot_gen #(
    parameter int N   = 12,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset_p,
    output logic [N-1:0] slot_cnt_o,
    output logic         period_tick_o
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  slot_q, slot_d;
    logic          slot_en;

    always_comb begin
        slot_en = (presc_q == PRESC_LAST);
        presc_d = slot_en ? '0 : presc_q + 1'b1;
        slot_d  = slot_en ? slot_q + 1'b1 : slot_q;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_q <= '0;
            slot_q  <= '0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
        end
    end

    assign slot_cnt_o    = slot_q;
    assign period_tick_o = slot_en && (slot_q == '1);

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan PWM stage: fixed-frequency PWM whose applied duty slews toward the
// latched target by a bounded step once per period.
module fan_pwm_ramp
    import fan_pwm_ramp_pkg::*;
#(
    parameter int SYS_FREQ = 125,
    parameter int N        = 12,
    parameter int PWM_FREQ = 200,
    parameter int RAMP_UP  = 64,
    parameter int RAMP_DN  = 128
) (
    input  logic           clk,
    input  logic           reset_p,
    fan_pwm_ramp_if.slave  bus
);
    localparam int DIV    = calc_div(SYS_FREQ, N, PWM_FREQ);
    localparam int SPAN   = 1 << N;
    localparam int UP_LIM = (RAMP_UP > SPAN) ? SPAN : RAMP_UP;
    localparam int DN_LIM = (RAMP_DN > SPAN) ? SPAN : RAMP_DN;
    localparam logic [N:0] UP_STEP = (N+1)'(UP_LIM);
    localparam logic [N:0] DN_STEP = (N+1)'(DN_LIM);

    logic [N-1:0] slot_cnt;
    logic         period_tick;

    fan_state_e   state_q, state_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] tgt_q, tgt_d;
    logic         pwm_q, pwm_d;
    logic         at_q, at_d;

    logic [N:0]   cur_w, tgt_w, up_gap, dn_gap, step_up, step_dn, stepped;

    pwm_slot_gen #(
        .N   (N),
        .DIV (DIV)
    ) u_slot_gen (
        .clk           (clk),
        .reset_p       (reset_p),
        .slot_cnt_o    (slot_cnt),
        .period_tick_o (period_tick)
    );

    // Wide arithmetic: the step is clamped to the gap, so no overshoot or wrap.
    always_comb begin
        tgt_d   = period_tick ? bus.duty_target : tgt_q;
        cur_w   = {1'b0, duty_q};
        tgt_w   = {1'b0, tgt_d};
        up_gap  = tgt_w - cur_w;
        dn_gap  = cur_w - tgt_w;
        step_up = (up_gap < UP_STEP) ? up_gap : UP_STEP;
        step_dn = (dn_gap < DN_STEP) ? dn_gap : DN_STEP;
        if (cur_w < tgt_w) begin
            stepped = cur_w + step_up;
        end else if (cur_w > tgt_w) begin
            stepped = cur_w - step_dn;
        end else begin
            stepped = cur_w;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (!bus.en) begin
            state_d = ST_STOP;
            duty_d  = '0;
        end else if (period_tick && !(state_q == ST_STOP && tgt_d == '0)) begin
            duty_d = stepped[N-1:0];
            if (stepped == tgt_w) begin
                state_d = (tgt_d == '0) ? ST_STOP : ST_HOLD;
            end else if (stepped < tgt_w) begin
                state_d = ST_RAMP_UP;
            end else begin
                state_d = ST_RAMP_DN;
            end
        end
    end

    // Full-scale code is treated as 100% so the top slot does not drop low.
    always_comb begin
        if (!bus.en || duty_q == '0) begin
            pwm_d = 1'b0;
        end else if (duty_q == '1) begin
            pwm_d = 1'b1;
        end else begin
            pwm_d = (slot_cnt < duty_q);
        end
        at_d = bus.en && (duty_d == tgt_d);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_STOP;
            duty_q  <= '0;
            tgt_q   <= '0;
            pwm_q   <= 1'b0;
            at_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            pwm_q   <= pwm_d;
            at_q    <= at_d;
        end
    end

    assign bus.pwm         = pwm_q;
    assign bus.duty_now    = duty_q;
    assign bus.period_tick = period_tick;
    assign bus.ramping     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DN);
    assign bus.at_target   = at_q;

endmodule

// File: doc/fan_pwm_ramp.md
Name: fan_pwm_ramp

Overview:
- Downstream stage of the fan speed FSM. Consumes the N-bit target duty code and drives the fan PWM pin.
- Generates a fixed-frequency PWM and slews the applied duty toward the target by a bounded step once per PWM period (soft start / soft stop).
- Duty is updated only at period boundaries, so the output is glitch-free.
- Reports ramp status for the LED/debug path.

Parameters:
- SYS_FREQ, 125, system clock frequency in MHz.
- N, 12, duty resolution in bits. One PWM period = 2^N duty slots.
- PWM_FREQ, 200, PWM frequency in Hz.
- RAMP_UP, 64, maximum duty increase per PWM period (codes, >=1).
- RAMP_DN, 128, maximum duty decrease per PWM period (codes, >=1).
- DIV, derived localparam = max(1, SYS_FREQ*1_000_000 / (PWM_FREQ*2^N)), integer truncation. Clocks per duty slot.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_p  in  1  asynchronous reset, active-high.
- en  in  1  run enable; 0 forces stop.
- duty_target  in  N  requested duty code, 0..2^N-1.
- pwm  out  1  PWM output.
- duty_now  out  N  duty code currently applied.
- period_tick  out  1  one-clk pulse on the last clock of each PWM period.
- ramping  out  1  high while state is RAMP_UP or RAMP_DN.
- at_target  out  1  high when duty_now == latched target and en=1.

Behaviour:
- Reset: pwm=0, duty_now=0, period_tick=0, ramping=0, at_target=0. Prescaler, slot counter and target latch cleared. State = STOP.
- Prescaler: counts 0..DIV-1 and emits slot_en when it is at DIV-1.
- Slot counter: N bits, advances on slot_en and wraps from 2^N-1 to 0. Period = DIV*2^N clocks.
- period_tick = slot_en AND slot_cnt == 2^N-1.
- PWM output is registered (1 clk latency from the counter):
  - duty_now == 0 -> pwm=0 for the whole period.
  - duty_now == 2^N-1 -> pwm=1 for the whole period (treated as 100%).
  - otherwise pwm = (slot_cnt < duty_now).
- Target latch: duty_target is sampled only on period_tick. A mid-period change has no effect until the next boundary.
- State machine (updates on period_tick unless stated otherwise):
  - STOP: duty_now=0. If en=1 and latched target > 0 -> RAMP_UP.
  - RAMP_UP: duty_now += min(RAMP_UP, tgt - duty_now).
  - RAMP_DN: duty_now -= min(RAMP_DN, duty_now - tgt).
  - HOLD: duty_now == tgt.
  - From any non-STOP state the next state follows the new duty vs target: == -> HOLD; < -> RAMP_UP; > -> RAMP_DN.
  - Reaching duty 0 with target 0 -> STOP.
- Arithmetic: differences and sums are computed in N+1 bits. A step never overshoots the target and never wraps past 0 or 2^N-1.
- en=0 (asynchronous to the period):
  - Same clock edge: duty_now=0, state=STOP, pwm=0 from the next clock.
  - Counters keep running and period_tick still pulses.
  - When en returns to 1, ramping restarts from 0 at the next boundary.
- Simultaneous events: en falling on a period_tick edge -> en wins. A target change on a period_tick edge -> the new value is latched.
- Reset mid-ramp: all state and outputs return to reset values immediately.

Decomposition:
- Shared fan package: state encodings (STOP, RAMP_UP, RAMP_DN, HOLD) and the DIV computation function, reused by fan_controller.
- One sub-module: pwm_slot_gen (prescaler + slot counter + period_tick).
- Ramp FSM and output compare stay in the top level.

Test Plan:
- Bench config: N=4, SYS_FREQ=1, PWM_FREQ=31250 -> DIV=2, period=32 clk, RAMP_UP=4, RAMP_DN=8.
  - Reset asserted mid-run -> all outputs 0 within the same cycle. After release, period_tick first pulses at clk 32.
  - en=1, target=15 from STOP -> duty_now steps 4,8,12,15 on successive period_ticks. ramping=1 until 15, then HOLD with at_target=1 and pwm high for entire periods.
  - From HOLD at 15, target=2 -> duty_now 7, then 2. Next state HOLD. pwm high for exactly 4 clocks (2 slots) per period.
  - Target changed 9->5 mid-period -> no duty change before the boundary. The step is applied at the next period_tick.
  - en dropped mid-period at duty 12 -> pwm=0 the next clock, duty_now=0, state STOP. When en is re-raised, ramp restarts at 4.
  - target=0 in STOP with en=1 -> remains STOP, pwm constantly 0, ramping=0.
